// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared types and helpers for the push-button step generator.
//   statetype - debounce / auto-repeat FSM states
//   cnt_width - width of the single shared counter, sized for the largest
//               terminal count among the three timing parameters
package step_gen_pkg;

  typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE} statetype;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous input.
//   clk   - destination clock
//   reset - asynchronous active-low reset, clears the chain
//   d     - asynchronous input level
//   q     - synchronised level, SYNC_STAGES edges behind d
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/step_gen.sv
// step_gen: turns a raw bouncing push-button into clean one-cycle enable
// strobes (one per press, plus optional auto-repeat while held).
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   btn       - raw button level, 1 = pressed
//   repeat_en - quasi-static auto-repeat enable
//   enable    - registered one-cycle strobe
//   pressed   - registered debounced button level
module step_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic repeat_en,
  output logic enable,
  output logic pressed
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic          btn_s;
  statetype      state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          strobe;
  logic          pressed_next;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      enable  <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      enable  <= strobe;
      pressed <= pressed_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    strobe     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (btn_s) next_state = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          next_state = HELD;
          cnt_next   = '0;
          strobe     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          next_state = DB_RELEASE;
          cnt_next   = '0;
        end else if (!repeat_en) begin
          cnt_next = '0;
        end else if (cnt == RD_LAST) begin
          next_state = REPEAT;
          cnt_next   = '0;
          strobe     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          next_state = DB_RELEASE;
          cnt_next   = '0;
        end else if (!repeat_en) begin
          next_state = HELD;
          cnt_next   = '0;
        end else if (cnt == RP_LAST) begin
          cnt_next = '0;
          strobe   = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DB_RELEASE: begin
        // A bounce back to 1 returns to HELD without a strobe.
        if (btn_s) begin
          next_state = HELD;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // pressed follows the state being entered so it changes on the same edge.
  always_comb begin
    pressed_next = (next_state == HELD) || (next_state == REPEAT) ||
                   (next_state == DB_RELEASE);
  end

endmodule

// File: tb/tb_step_gen.sv
// tb_step_gen: self-checking bench for step_gen with small timing parameters.
module tb_step_gen;

  localparam int unsigned SS = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic repeat_en = 1'b0;
  logic enable;
  logic pressed;

  int unsigned total = 0;
  int unsigned bad = 0;

  step_gen #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .repeat_en (repeat_en),
    .enable    (enable),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: run lengths of synchronised samples.
  // A press is accepted after DB+1 consecutive high samples, a release after
  // DB+1 consecutive low samples; repeats count qualifying held samples.
  bit          mq[$];
  bit          m_pressed, m_en, rep_phase;
  int unsigned hi_run, lo_run, rep_run;

  function void model_reset();
    mq.delete();
    for (int i = 0; i < SS; i++) mq.push_back(1'b0);
    m_pressed = 0; m_en = 0; rep_phase = 0;
    hi_run = 0; lo_run = 0; rep_run = 0;
  endfunction

  function void model_edge(bit b, bit re);
    bit bs;
    bs = mq.pop_front();
    mq.push_back(b);
    m_en = 0;
    if (!m_pressed) begin
      hi_run = bs ? hi_run + 1 : 0;
      if (hi_run == DB + 1) begin
        m_pressed = 1; m_en = 1;
        hi_run = 0; lo_run = 0; rep_run = 0; rep_phase = 0;
      end
    end else if (!bs) begin
      lo_run++;
      rep_run = 0; rep_phase = 0;
      if (lo_run == DB + 1) begin
        m_pressed = 0; lo_run = 0; hi_run = 0;
      end
    end else if (lo_run != 0 || !re) begin
      lo_run = 0; rep_run = 0; rep_phase = 0;
    end else begin
      rep_run++;
      if (rep_run == (rep_phase ? RP : RD)) begin
        m_en = 1; rep_phase = 1; rep_run = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic re);
    btn = b;
    repeat_en = re;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge(b, re);
    #1;
    check("model_enable", enable, m_en);
    check("model_pressed", pressed, m_pressed);
  endtask

  typedef struct {
    logic        b;
    logic        re;
    int unsigned n;
    int unsigned cnt;
    int unsigned first;
    int unsigned last;
    logic        p;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    int unsigned c, f, l;
    logic lvl, re;
    int unsigned len;

    tbl[0]  = '{1'b0, 1'b0, 20, 0, 0,  0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 40, 1, 7,  7, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 10, 0, 0,  0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0,  2, 0, 0,  0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 10, 0, 0,  0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0,  4, 0, 0,  0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0,  1, 0, 0,  0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 20, 1, 7,  7, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 10, 0, 0,  0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 34, 5, 7, 32, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 10, 0, 0,  0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 20, 2, 7, 17, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 30, 0, 0,  0, 1'b1};
    tbl[13] = '{1'b0, 1'b0,  3, 0, 0,  0, 1'b1};
    tbl[14] = '{1'b1, 1'b0,  1, 0, 0,  0, 1'b1};
    tbl[15] = '{1'b0, 1'b0,  6, 0, 0,  0, 1'b1};
    tbl[16] = '{1'b0, 1'b0,  1, 0, 0,  0, 1'b0};

    model_reset();

    // Reset held with a toggling button.
    for (int i = 0; i < 3; i++) begin
      step(i % 2 == 0, 1'b0);
      check("reset_enable", enable, 1'b0);
      check("reset_pressed", pressed, 1'b0);
    end
    reset = 1'b1;

    // Table-driven segments.
    for (int r = 0; r < NV; r++) begin
      c = 0; f = 0; l = 0;
      for (int unsigned k = 1; k <= tbl[r].n; k++) begin
        step(tbl[r].b, tbl[r].re);
        if (enable) begin
          c++;
          if (f == 0) f = k;
          l = k;
          check($sformatf("row%0d_pressed_at_strobe", r), pressed, 1'b1);
        end
      end
      check($sformatf("row%0d_strobes", r), c, tbl[r].cnt);
      check($sformatf("row%0d_first", r), f, tbl[r].first);
      check($sformatf("row%0d_last", r), l, tbl[r].last);
      check($sformatf("row%0d_pressed", r), pressed, tbl[r].p);
    end

    // Reset asserted mid-REPEAT, between edges 18 and 19.
    for (int k = 0; k < 18; k++) step(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_enable", enable, 1'b0);
    check("async_pressed", pressed, 1'b0);
    model_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b1;
    f = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1);
      if (enable && f == 0) f = k;
    end
    check("post_reset_first", f, 7);

    // Randomised segments against the reference model.
    for (int s = 0; s < 250; s++) begin
      lvl = (s % 2) == 0;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
      re  = ($urandom_range(0, 3) != 0);
      for (int unsigned k = 0; k < len; k++) begin
        if ($urandom_range(0, 30) == 0) re = ~re;
        step(lvl, re);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
